// File: rtl/gic_slave.sv
// GIC link slave: nibble-serial command receiver driving one classic Wishbone cycle.
// Optional GIC_SLAVE_IRQ_EN adds irq_i, returned in place of a bus read for irq commands.
module gic_slave #(
    parameter logic [3:0] IDLE       = 4'b1111,
    parameter logic [7:0] WB_TIMEOUT = 8'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  gic_dat_i,
    output logic [3:0]  gic_dat_o,
    input  logic        gic_cs_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
`ifdef GIC_SLAVE_IRQ_EN
    input  logic [31:0] irq_i,
`endif
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    typedef enum logic [3:0] {
        RX_INIT,
        RX_CMD,
        RX_SEL,
        RX_ADR,
        RX_DAT,
        RX_CKSUM,
        WB,
        WAIT_CS,
        TX_INIT,
        TX_RESP,
        TX_DAT,
        TX_CKSUM
    } state_t;

    localparam logic [3:0] SYNC_RX = 4'b1010;
    localparam logic [3:0] SYNC_TX = 4'b0101;
    localparam logic [3:0] CK_LAST = 4'b1100;

    state_t      state;
    state_t      state_n;
    logic [2:0]  k;
    logic [2:0]  k_n;
    logic [3:0]  t;
    logic [3:0]  t_n;
    logic [3:0]  dat_n;
    logic [3:0]  c;
    logic [3:0]  ck_last;
    logic [3:0]  tx_nib;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        tx_rd;
    logic        cmd_we;
    logic        cmd_irq;
    logic [7:0]  wb_cnt;
    logic        wb_done;
    logic        ck_ok;

    function automatic logic [3:0] nib(input logic [31:0] w,
                                       input logic [2:0]  i);
        return w[{i, 2'b00} +: 4];
    endfunction

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    assign ck_last = (k == 3'd0) ? CK_LAST : 4'b0000;
    assign tx_nib  = nib(rdata, k);
    assign ck_ok   = (gic_dat_i == c);
    assign wb_done = wb_ack_i | wb_err_i | wb_rty_i
                   | (wb_cnt == WB_TIMEOUT);

    always_comb begin
        state_n = state;
        k_n     = k;
        t_n     = t;
        dat_n   = IDLE;
        unique case (state)
            RX_INIT: begin
                if (!gic_cs_i && gic_dat_i == SYNC_RX)
                    state_n = RX_CMD;
            end
            RX_CMD: begin
                // rty asks for the previous answer again
                state_n = gic_dat_i[1] ? WAIT_CS : RX_SEL;
            end
            RX_SEL: begin
                state_n = RX_ADR;
                k_n     = 3'd7;
            end
            RX_ADR: begin
                if (k == 3'd0) begin
                    state_n = cmd_we ? RX_DAT : RX_CKSUM;
                    k_n     = 3'd7;
                end else begin
                    k_n = k - 3'd1;
                end
            end
            RX_DAT: begin
                if (k == 3'd0)
                    state_n = RX_CKSUM;
                else
                    k_n = k - 3'd1;
            end
            RX_CKSUM: begin
                state_n = (ck_ok && !cmd_irq) ? WB : WAIT_CS;
            end
            WB: begin
                if (wb_done)
                    state_n = WAIT_CS;
            end
            WAIT_CS: begin
                if (gic_cs_i) begin
                    state_n = TX_INIT;
                    dat_n   = SYNC_TX;
                end
            end
            TX_INIT: begin
                if (!gic_cs_i) begin
                    state_n = RX_INIT;
                end else begin
                    state_n = TX_RESP;
                    dat_n   = {resp, 2'b00};
                end
            end
            TX_RESP: begin
                if (!gic_cs_i) begin
                    state_n = RX_INIT;
                end else if (tx_rd) begin
                    state_n = TX_DAT;
                    k_n     = 3'd7;
                    t_n     = 4'b0000;
                    dat_n   = nib(rdata, 3'd7);
                end else begin
                    state_n = RX_INIT;
                end
            end
            TX_DAT: begin
                if (!gic_cs_i) begin
                    state_n = RX_INIT;
                end else begin
                    t_n = t ^ tx_nib ^ ck_last;
                    if (k == 3'd0) begin
                        state_n = TX_CKSUM;
                        dat_n   = t_n;
                    end else begin
                        k_n   = k - 3'd1;
                        dat_n = nib(rdata, k_n);
                    end
                end
            end
            TX_CKSUM: begin
                state_n = RX_INIT;
            end
            default: begin
                state_n = RX_INIT;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= RX_INIT;
            k         <= 3'd0;
            t         <= 4'b0000;
            c         <= 4'b0000;
            gic_dat_o <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= 32'd0;
            wb_dat_o  <= 32'd0;
            wb_sel_o  <= 4'b0000;
            resp      <= 2'b00;
            rdata     <= 32'd0;
            tx_rd     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_irq   <= 1'b0;
            wb_cnt    <= 8'd0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            t         <= t_n;
            gic_dat_o <= dat_n;
            case (state)
                RX_CMD: begin
                    cmd_we  <= gic_dat_i[3];
                    cmd_irq <= gic_dat_i[2];
                end
                RX_SEL: begin
                    wb_sel_o <= gic_dat_i;
                    c        <= gic_dat_i;
                end
                RX_ADR: begin
                    wb_adr_o <= {wb_adr_o[27:0], gic_dat_i};
                    c        <= c ^ gic_dat_i ^ ck_last;
                end
                RX_DAT: begin
                    wb_dat_o <= {wb_dat_o[27:0], gic_dat_i};
                    c        <= c ^ gic_dat_i ^ ck_last;
                end
                RX_CKSUM: begin
                    tx_rd <= !cmd_we;
                    if (!ck_ok) begin
                        resp  <= 2'b01;
                        rdata <= 32'd0;
                    end else if (cmd_irq) begin
`ifdef GIC_SLAVE_IRQ_EN
                        resp  <= 2'b00;
                        rdata <= irq_i;
                        tx_rd <= 1'b1;
`else
                        resp  <= 2'b10;
                        rdata <= 32'd0;
`endif
                    end else begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= cmd_we;
                        wb_cnt   <= 8'd0;
                    end
                end
                WB: begin
                    if (wb_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        rdata    <= 32'd0;
                        if (wb_ack_i) begin
                            resp <= 2'b00;
                            if (!wb_we_o)
                                rdata <= wb_dat_i;
                        end else if (wb_err_i) begin
                            resp <= 2'b10;
                        end else if (wb_rty_i) begin
                            resp <= 2'b11;
                        end else begin
                            resp <= 2'b10;
                        end
                    end else if (wb_cnt != WB_TIMEOUT) begin
                        wb_cnt <= wb_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gic_slave.sv
// Directed bench for gic_slave: table of GIC frames with hand-computed answers,
// plus reset, abort and rty-replay sequences.
module tb_gic_slave;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_RTY  = 2;
    localparam int M_NONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  gic_dat_i = 4'hF;
    logic [3:0]  gic_dat_o;
    logic        gic_cs_i = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
`ifdef GIC_SLAVE_IRQ_EN
    logic [31:0] irq_i = 32'hA5A5_0F0F;
`endif

    always #5 clk = ~clk;

    gic_slave dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .gic_dat_i(gic_dat_i),
        .gic_dat_o(gic_dat_o),
        .gic_cs_i (gic_cs_i),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_cti_o (wb_cti_o),
        .wb_bte_o (wb_bte_o),
`ifdef GIC_SLAVE_IRQ_EN
        .irq_i    (irq_i),
`endif
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  ck;
        int          mode;
        logic [31:0] rdat;
        logic        exp_cyc;
        logic [3:0]  exp_resp;
        logic        exp_txd;
        logic [31:0] exp_dat;
        logic [3:0]  exp_tck;
    } vec_t;

    vec_t vecs[11];

    int          errors = 0;
    int          checks = 0;
    int          mode = M_ACK;
    logic [31:0] rdat = 32'd0;
    int          cyc_cnt = 0;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    // Local-bus slave model: answers one cycle after it sees a strobe
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_cyc_o && wb_stb_o) begin
            cyc_cnt++;
            cap_adr = wb_adr_o;
            cap_dat = wb_dat_o;
            cap_sel = wb_sel_o;
            cap_we  = wb_we_o;
            case (mode)
                M_ACK: begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rdat;
                end
                M_ERR: wb_err_i = 1'b1;
                M_RTY: wb_rty_i = 1'b1;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        gic_cs_i  = 1'b0;
        gic_dat_i = n;
    endtask

    task automatic send_frame(input vec_t v);
        send_nib(4'b1010);
        send_nib(v.cmd);
        send_nib(v.sel);
        for (int j = 7; j >= 0; j--) send_nib(v.adr[j*4 +: 4]);
        if (v.cmd[3])
            for (int j = 7; j >= 0; j--) send_nib(v.wdat[j*4 +: 4]);
        send_nib(v.ck);
    endtask

    task automatic wait_bus(input string tag);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            gic_dat_i = 4'hF;
            if (!wb_cyc_o) break;
            n++;
        end
        if (n >= 400) check({tag, " bus timeout"}, 32'd1, 32'd0);
        check({tag, " idle while cs=0"}, gic_dat_o, 4'hF);
    endtask

    task automatic rx_frame(input string tag, input vec_t v);
        logic [31:0] d;
        @(negedge clk);
        gic_cs_i  = 1'b1;
        gic_dat_i = 4'hF;
        @(negedge clk);
        check({tag, " tx_init"}, gic_dat_o, 4'b0101);
        @(negedge clk);
        check({tag, " resp"}, gic_dat_o, v.exp_resp);
        if (v.exp_txd) begin
            d = 32'd0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                d = {d[27:0], gic_dat_o};
            end
            check({tag, " data"}, d, v.exp_dat);
            @(negedge clk);
            check({tag, " tx_cksum"}, gic_dat_o, v.exp_tck);
        end
        @(negedge clk);
        check({tag, " idle after"}, gic_dat_o, 4'hF);
        gic_cs_i = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        mode    = v.mode;
        rdat    = v.rdat;
        cyc_cnt = 0;
        send_frame(v);
        wait_bus(tag);
        check({tag, " cyc seen"}, 32'(cyc_cnt > 0), 32'(v.exp_cyc));
        if (v.exp_cyc) begin
            check({tag, " adr"}, cap_adr, v.adr);
            check({tag, " sel"}, cap_sel, v.sel);
            check({tag, " we"}, cap_we, v.cmd[3]);
            if (v.cmd[3]) check({tag, " wdat"}, cap_dat, v.wdat);
        end
        if (v.mode == M_NONE && v.exp_cyc)
            check({tag, " timeout len"},
                  32'(cyc_cnt >= 255 && cyc_cnt <= 257), 32'd1);
        rx_frame(tag, v);
    endtask

    initial begin
        vec_t rv;
        //          cmd   sel   adr           wdat          ck    mode   rdat
        //          cyc   resp  txd dat          tck
        vecs[0]  = '{4'h0, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_ACK, 32'h1234_5678,
                     1'b1, 4'h0, 1'b1, 32'h1234_5678, 4'h4};
        vecs[1]  = '{4'h8, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 4'hE, M_ACK, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 4'h0};
        vecs[2]  = '{4'h0, 4'hF, 32'h0000_0004, 32'h0, 4'h6, M_ACK, 32'h1234_5678,
                     1'b0, 4'h4, 1'b1, 32'h0, 4'hC};
        vecs[3]  = '{4'h0, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_ERR, 32'h0,
                     1'b1, 4'h8, 1'b1, 32'h0, 4'hC};
        vecs[4]  = '{4'h0, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_RTY, 32'h0,
                     1'b1, 4'hC, 1'b1, 32'h0, 4'hC};
        vecs[5]  = '{4'h0, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_NONE, 32'h0,
                     1'b1, 4'h8, 1'b1, 32'h0, 4'hC};
        vecs[6]  = '{4'h0, 4'h3, 32'h8000_0001, 32'h0, 4'h6, M_ACK, 32'h0000_00A5,
                     1'b1, 4'h0, 1'b1, 32'h0000_00A5, 4'h3};
        vecs[7]  = '{4'h8, 4'h1, 32'h0000_0000, 32'h0000_0001, 4'h0, M_ACK, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 4'h0};
`ifdef GIC_SLAVE_IRQ_EN
        vecs[8]  = '{4'h4, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_ACK, 32'h0,
                     1'b0, 4'h0, 1'b1, 32'hA5A5_0F0F, 4'hC};
`else
        vecs[8]  = '{4'h4, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_ACK, 32'h0,
                     1'b0, 4'h8, 1'b1, 32'h0, 4'hC};
`endif
        vecs[9]  = '{4'h1, 4'hF, 32'h0000_0004, 32'h0, 4'h7, M_ACK, 32'h0F0F_0F0F,
                     1'b1, 4'h0, 1'b1, 32'h0F0F_0F0F, 4'hC};
        vecs[10] = '{4'h8, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 4'hE, M_ERR, 32'h0,
                     1'b1, 4'h8, 1'b0, 32'h0, 4'h0};

        repeat (3) @(negedge clk);
        check("rst cyc", wb_cyc_o, 1'b0);
        check("rst stb", wb_stb_o, 1'b0);
        check("rst we", wb_we_o, 1'b0);
        check("rst dat_o", gic_dat_o, 4'hF);
        check("rst adr", wb_adr_o, 32'h0);
        check("rst sel", wb_sel_o, 4'h0);
        check("cti", wb_cti_o, 3'b000);
        check("bte", wb_bte_o, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // rty replay after a good read
        run_vec("pre-rty", vecs[0]);
        cyc_cnt = 0;
        send_nib(4'b1010);
        send_nib(4'b0010);
        wait_bus("rty");
        check("rty no cyc", cyc_cnt, 0);
        rx_frame("rty", vecs[0]);

        // master drops cs mid-transmit; answer must survive for a replay
        run_vec("pre-abort", vecs[6]);
        send_nib(4'b1010);
        send_nib(4'b0010);
        wait_bus("abort");
        @(negedge clk);
        gic_cs_i = 1'b1;
        @(negedge clk);
        check("abort init", gic_dat_o, 4'b0101);
        @(negedge clk);
        check("abort resp", gic_dat_o, 4'h0);
        gic_cs_i = 1'b0;
        @(negedge clk);
        check("abort idle", gic_dat_o, 4'hF);
        cyc_cnt = 0;
        send_nib(4'b1010);
        send_nib(4'b0010);
        wait_bus("abort rty");
        check("abort rty no cyc", cyc_cnt, 0);
        rx_frame("abort rty", vecs[6]);

        // reset in the middle of the address phase
        send_nib(4'b1010);
        send_nib(4'h0);
        send_nib(4'hF);
        send_nib(4'h0);
        send_nib(4'h0);
        send_nib(4'h0);
        @(negedge clk);
        rst = 1'b1;
        gic_dat_i = 4'hF;
        @(negedge clk);
        check("rst adr-phase cyc", wb_cyc_o, 1'b0);
        check("rst adr-phase dat_o", gic_dat_o, 4'hF);
        rst = 1'b0;
        run_vec("after rst1", vecs[0]);

        // reset while the bus cycle is pending
        rv      = vecs[0];
        mode    = M_NONE;
        send_frame(rv);
        repeat (5) @(negedge clk);
        gic_dat_i = 4'hF;
        check("in wb cyc", wb_cyc_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst wb cyc", wb_cyc_o, 1'b0);
        check("rst wb dat_o", gic_dat_o, 4'hF);
        check("rst wb adr", wb_adr_o, 32'h0);
        rst = 1'b0;
        run_vec("after rst2", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
